// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: drives datapath load enables, bus gates, mux selects and SRAM strobes.
// Latency: outputs are registered and always reflect the current state; memory states last MEM_WAIT+1 cycles.
// Backpressure: none; the only stalls are the memory wait counter and the Continue handshake in PAUSE.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    typedef enum logic [4:0] {
        HALTED, FETCH1, FETCH2, FETCH3, DECODE,
        S_ADD, S_AND, S_NOT, BR, BR_TAKE, JMP,
        JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3,
        PAUSE1, PAUSE2
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic       mio_en;
        logic       mem_ce;
        logic       mem_ub;
        logic       mem_lb;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    state_t     state;
    state_t     nxt_state;
    logic [2:0] cnt;
    logic [2:0] nxt_cnt;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_nxt;

    // Control word for a given state. The wait count only matters for the
    // read states, where the MDR is loaded on the last cycle of the hold.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] c,
                                          input logic ir5, input logic ir11);
        ctrl_t o;
        o        = '0;
        o.mem_ce = 1'b1;
        o.mem_ub = 1'b1;
        o.mem_lb = 1'b1;
        o.mem_oe = 1'b1;
        o.mem_we = 1'b1;
        case (s)
            FETCH1: begin
                o.gate_pc = 1'b1;
                o.ld_mar  = 1'b1;
                o.ld_pc   = 1'b1;
            end
            FETCH2, LDR2: begin
                o.mem_oe = 1'b0;
                o.mio_en = 1'b1;
                o.ld_mdr = (c == 3'd0);
            end
            FETCH3: begin
                o.gate_mdr = 1'b1;
                o.ld_ir    = 1'b1;
            end
            DECODE: o.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                o.gate_alu = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
                o.sr1mux   = 1'b1;
                if (s == S_NOT) begin
                    o.aluk = 2'b10;
                end else begin
                    o.sr2mux = ir5;
                    o.aluk   = (s == S_AND) ? 2'b01 : 2'b00;
                end
            end
            BR_TAKE: begin
                o.ld_pc    = 1'b1;
                o.pcmux    = 2'b10;
                o.addr2mux = 2'b10;
            end
            JMP: begin
                o.ld_pc    = 1'b1;
                o.pcmux    = 2'b10;
                o.addr1mux = 1'b1;
                o.sr1mux   = 1'b1;
            end
            JSR1: begin
                o.gate_pc = 1'b1;
                o.ld_reg  = 1'b1;
                o.drmux   = 1'b1;
            end
            JSR2: begin
                o.ld_pc = 1'b1;
                o.pcmux = 2'b10;
                if (ir11) begin
                    o.addr2mux = 2'b11;
                end else begin
                    o.addr1mux = 1'b1;
                    o.sr1mux   = 1'b1;
                end
            end
            LDR1, STR1: begin
                o.gate_marmux = 1'b1;
                o.ld_mar      = 1'b1;
                o.addr1mux    = 1'b1;
                o.addr2mux    = 2'b01;
                o.sr1mux      = 1'b1;
            end
            LDR3: begin
                o.gate_mdr = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
            end
            STR2: begin
                o.gate_alu = 1'b1;
                o.aluk     = 2'b11;
                o.ld_mdr   = 1'b1;
            end
            STR3: o.mem_we = 1'b0;
            PAUSE1, PAUSE2: o.ld_led = 1'b1;
            default: ;
        endcase
        // Chip and byte enables follow any active memory strobe.
        if (!o.mem_oe || !o.mem_we) begin
            o.mem_ce = 1'b0;
            o.mem_ub = 1'b0;
            o.mem_lb = 1'b0;
        end
        return o;
    endfunction

    // Next state, next wait count and the control word that goes with them.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            HALTED:  if (Run) nxt_state = FETCH1;
            FETCH1: begin
                nxt_state = FETCH2;
                nxt_cnt   = WAIT_LOAD;
            end
            FETCH2:  if (cnt == 3'd0) nxt_state = FETCH3; else nxt_cnt = cnt - 3'd1;
            FETCH3:  nxt_state = DECODE;
            DECODE: begin
                case (Opcode)
                    4'b0001: nxt_state = S_ADD;
                    4'b0101: nxt_state = S_AND;
                    4'b1001: nxt_state = S_NOT;
                    4'b0000: nxt_state = BR;
                    4'b1100: nxt_state = JMP;
                    4'b0100: nxt_state = JSR1;
                    4'b0110: nxt_state = LDR1;
                    4'b0111: nxt_state = STR1;
                    4'b1101: nxt_state = PAUSE1;
                    default: nxt_state = FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, BR_TAKE, JMP, JSR2, LDR3: nxt_state = FETCH1;
            BR:      nxt_state = BEN ? BR_TAKE : FETCH1;
            JSR1:    nxt_state = JSR2;
            LDR1: begin
                nxt_state = LDR2;
                nxt_cnt   = WAIT_LOAD;
            end
            LDR2:    if (cnt == 3'd0) nxt_state = LDR3; else nxt_cnt = cnt - 3'd1;
            STR1:    nxt_state = STR2;
            STR2: begin
                nxt_state = STR3;
                nxt_cnt   = WAIT_LOAD;
            end
            STR3:    if (cnt == 3'd0) nxt_state = FETCH1; else nxt_cnt = cnt - 3'd1;
            PAUSE1:  if (Continue) nxt_state = PAUSE2;
            PAUSE2:  if (!Continue) nxt_state = FETCH1;
            default: nxt_state = HALTED;
        endcase
        ctrl_nxt = decode_ctrl(nxt_state, nxt_cnt, IR_5, IR_11);
    end

    // State, wait counter and registered control word; reset parks everything in HALTED.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= HALTED;
            cnt    <= 3'd0;
            ctrl_q <= decode_ctrl(HALTED, 3'd0, 1'b0, 1'b0);
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            ctrl_q <= ctrl_nxt;
        end
    end

    assign LD_MAR     = ctrl_q.ld_mar;
    assign LD_MDR     = ctrl_q.ld_mdr;
    assign LD_IR      = ctrl_q.ld_ir;
    assign LD_BEN     = ctrl_q.ld_ben;
    assign LD_CC      = ctrl_q.ld_cc;
    assign LD_REG     = ctrl_q.ld_reg;
    assign LD_PC      = ctrl_q.ld_pc;
    assign LD_LED     = ctrl_q.ld_led;
    assign GatePC     = ctrl_q.gate_pc;
    assign GateMDR    = ctrl_q.gate_mdr;
    assign GateALU    = ctrl_q.gate_alu;
    assign GateMARMUX = ctrl_q.gate_marmux;
    assign PCMUX      = ctrl_q.pcmux;
    assign ADDR2MUX   = ctrl_q.addr2mux;
    assign ALUK       = ctrl_q.aluk;
    assign DRMUX      = ctrl_q.drmux;
    assign SR1MUX     = ctrl_q.sr1mux;
    assign SR2MUX     = ctrl_q.sr2mux;
    assign ADDR1MUX   = ctrl_q.addr1mux;
    assign MIO_EN     = ctrl_q.mio_en;
    assign Mem_CE     = ctrl_q.mem_ce;
    assign Mem_UB     = ctrl_q.mem_ub;
    assign Mem_LB     = ctrl_q.mem_lb;
    assign Mem_OE     = ctrl_q.mem_oe;
    assign Mem_WE     = ctrl_q.mem_we;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: per-instruction expected cycle sequences go into a scoreboard queue,
// a negedge monitor pops one entry per cycle and compares the whole control word.
// Directed checks cover reset, including an asynchronous reset in the middle of a fetch read.
module tb_lc3_control_fsm;

    localparam int MW = 2;

    logic       clk = 1'b0;
    logic       rst, run, cont, ir5, ir11, ben;
    logic [3:0] opcode;
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux, mio_en;
    logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we;

    always #5 clk = ~clk;

    lc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(clk), .Reset(rst), .Run(run), .Continue(cont),
        .Opcode(opcode), .IR_5(ir5), .IR_11(ir11), .BEN(ben),
        .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
        .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
        .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu), .GateMARMUX(gate_marmux),
        .PCMUX(pcmux), .ADDR2MUX(addr2mux), .ALUK(aluk),
        .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux),
        .MIO_EN(mio_en),
        .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb), .Mem_OE(mem_oe), .Mem_WE(mem_we)
    );

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       drmux, sr1mux, sr2mux, addr1mux, mio_en;
        logic       ce, ub, lb, oe, we;
    } sig_t;

    sig_t obs;
    assign obs = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                  gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux, aluk,
                  drmux, sr1mux, sr2mux, addr1mux, mio_en,
                  mem_ce, mem_ub, mem_lb, mem_oe, mem_we};

    sig_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    function automatic sig_t idle();
        sig_t v;
        v = '0;
        v.ce = 1'b1; v.ub = 1'b1; v.lb = 1'b1; v.oe = 1'b1; v.we = 1'b1;
        return v;
    endfunction

    function automatic sig_t mem_rd(input bit last);
        sig_t v;
        v = idle();
        v.ce = 1'b0; v.ub = 1'b0; v.lb = 1'b0; v.oe = 1'b0;
        v.mio_en = 1'b1;
        v.ld_mdr = last;
        return v;
    endfunction

    function automatic sig_t mem_wr();
        sig_t v;
        v = idle();
        v.ce = 1'b0; v.ub = 1'b0; v.lb = 1'b0; v.we = 1'b0;
        return v;
    endfunction

    function automatic sig_t fetch1();
        sig_t v;
        v = idle();
        v.gate_pc = 1'b1; v.ld_mar = 1'b1; v.ld_pc = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input sig_t got, input sig_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // Scoreboard monitor: one expected control word per clock cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL seq_underflow at %0t: got %h with no expected entry", $time, obs);
            end else begin
                check("seq", obs, exp_q.pop_front());
            end
        end
    end

    // Build the expected cycle-by-cycle behaviour of one instruction from the
    // ISA's micro-sequence, queue it, then drive the inputs for those cycles.
    task automatic issue(input logic [3:0] op, input logic i5, input logic i11,
                         input logic b, input bit with_halt);
        sig_t seq[$];
        bit   cq[$];
        sig_t v;
        int   hold1, hold2;
        hold1 = $urandom_range(0, 3);
        hold2 = $urandom_range(0, 3);
        if (with_halt) begin
            seq.push_back(idle()); cq.push_back(1'($urandom_range(0, 1)));
        end
        seq.push_back(fetch1()); cq.push_back(1'($urandom_range(0, 1)));
        for (int w = 0; w <= MW; w++) begin
            seq.push_back(mem_rd(w == MW)); cq.push_back(1'($urandom_range(0, 1)));
        end
        v = idle(); v.gate_mdr = 1'b1; v.ld_ir = 1'b1;
        seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
        v = idle(); v.ld_ben = 1'b1;
        seq.push_back(v); cq.push_back(op == 4'b1101 ? 1'b0 : 1'($urandom_range(0, 1)));
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                v = idle(); v.gate_alu = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1; v.sr1mux = 1'b1;
                if (op == 4'b1001) v.aluk = 2'b10;
                else begin
                    v.sr2mux = i5;
                    v.aluk   = (op == 4'b0101) ? 2'b01 : 2'b00;
                end
                seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
            end
            4'b0000: begin
                seq.push_back(idle()); cq.push_back(1'($urandom_range(0, 1)));
                if (b) begin
                    v = idle(); v.ld_pc = 1'b1; v.pcmux = 2'b10; v.addr2mux = 2'b10;
                    seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
                end
            end
            4'b1100: begin
                v = idle(); v.ld_pc = 1'b1; v.pcmux = 2'b10; v.addr1mux = 1'b1; v.sr1mux = 1'b1;
                seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
            end
            4'b0100: begin
                v = idle(); v.gate_pc = 1'b1; v.ld_reg = 1'b1; v.drmux = 1'b1;
                seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
                v = idle(); v.ld_pc = 1'b1; v.pcmux = 2'b10;
                if (i11) v.addr2mux = 2'b11;
                else begin v.addr1mux = 1'b1; v.sr1mux = 1'b1; end
                seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
            end
            4'b0110, 4'b0111: begin
                v = idle(); v.gate_marmux = 1'b1; v.ld_mar = 1'b1; v.addr1mux = 1'b1;
                v.addr2mux = 2'b01; v.sr1mux = 1'b1;
                seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
                if (op == 4'b0110) begin
                    for (int w = 0; w <= MW; w++) begin
                        seq.push_back(mem_rd(w == MW)); cq.push_back(1'($urandom_range(0, 1)));
                    end
                    v = idle(); v.gate_mdr = 1'b1; v.ld_reg = 1'b1; v.ld_cc = 1'b1;
                    seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
                end else begin
                    v = idle(); v.gate_alu = 1'b1; v.aluk = 2'b11; v.ld_mdr = 1'b1;
                    seq.push_back(v); cq.push_back(1'($urandom_range(0, 1)));
                    for (int w = 0; w <= MW; w++) begin
                        seq.push_back(mem_wr()); cq.push_back(1'($urandom_range(0, 1)));
                    end
                end
            end
            4'b1101: begin
                v = idle(); v.ld_led = 1'b1;
                for (int k = 0; k < hold1; k++) begin seq.push_back(v); cq.push_back(1'b0); end
                seq.push_back(v); cq.push_back(1'b1);
                for (int k = 0; k < hold2; k++) begin seq.push_back(v); cq.push_back(1'b1); end
                seq.push_back(v); cq.push_back(1'b0);
            end
            default: ;
        endcase
        opcode = op; ir5 = i5; ir11 = i11; ben = b;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        for (int i = 0; i < seq.size(); i++) begin
            cont = cq[i];
            run  = (with_halt && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_issue();
        issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected entries left, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; run = 1'b0; cont = 1'b0; opcode = 4'd0; ir5 = 1'b0; ir11 = 1'b0; ben = 1'b0;
        #3;
        check("reset_idle", obs, idle());
        @(posedge clk); #1;
        rst = 1'b0;
        check("halted_after_reset", obs, idle());
        @(posedge clk); #1;
        check("halted_no_run", obs, idle());

        mon_en = 1'b1;
        issue(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (60) random_issue();
        mon_en = 1'b0;
        check_drained("drain_1");

        // The sequencer now sits in FETCH1; reset it asynchronously mid-read.
        check("fetch1_before_reset", obs, fetch1());
        @(posedge clk); #1;
        check("fetch2_before_reset", obs, mem_rd(MW == 0));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_fetch", obs, idle());
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cont = 1'($urandom_range(0, 1));
            check("halted_hold", obs, idle());
            @(posedge clk); #1;
        end

        mon_en = 1'b1;
        issue(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (10) random_issue();
        mon_en = 1'b0;
        check_drained("drain_2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
